ace_ccu_snoop_fanout: RTL



---
 rtl/ccu_pkg.sv | 54 +++++
 rtl/ace_ccu_snoop_fanout_lzc.sv | 27 ++
 rtl/ace_ccu_snoop_fanout.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/ccu_pkg.sv
// Shared types for the CCU snoop path: ACE snoop channel structs, CR response
// bit positions and the snoop fan-out FSM state encoding.
package ccu_pkg;

  localparam int unsigned CrDataTransfer = 0;
  localparam int unsigned CrError        = 1;
  localparam int unsigned CrPassDirty    = 2;
  localparam int unsigned CrIsShared     = 3;
  localparam int unsigned CrWasUnique    = 4;

  localparam int unsigned AcAddrWidth = 32;
  localparam int unsigned CdDataWidth = 64;

  typedef enum logic [1:0] {
    FanoutIdle  = 2'd0,
    FanoutBcast = 2'd1,
    FanoutResp  = 2'd2,
    FanoutData  = 2'd3
  } fanout_state_e;

  typedef logic [4:0] ace_crresp_t;

  typedef struct packed {
    logic [AcAddrWidth-1:0] addr;
    logic [3:0]             snoop;
    logic [2:0]             prot;
  } ace_ac_t;

  typedef struct packed {
    logic [CdDataWidth-1:0] data;
    logic                   last;
  } ace_cd_t;

  typedef struct packed {
    ace_ac_t ac;
    logic    ac_valid;
    logic    cr_ready;
    logic    cd_ready;
  } snoop_req_t;

  typedef struct packed {
    logic        ac_ready;
    logic        cr_valid;
    ace_crresp_t cr_resp;
    logic        cd_valid;
    ace_cd_t     cd;
  } snoop_resp_t;

  // Every CR bit merges by OR, so the result does not depend on arrival order.
  function automatic ace_crresp_t merge_crresp(input ace_crresp_t acc, input ace_crresp_t resp);
    return acc | resp;
  endfunction

endpackage

// File: rtl/ace_ccu_snoop_fanout_lzc.sv
// Leading/trailing zero counter; MODE=0 counts trailing zeros, which gives the
// index of the lowest set bit. The count is 0 when the input is all zeros.
module lzc #(
  parameter int unsigned WIDTH     = 2,
  parameter bit          MODE      = 1'b0,
  parameter int unsigned CNT_WIDTH = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0]     in_i,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic                 empty_o
);

  // Scan so that the bit nearest the counted end is written last and wins.
  always_comb begin
    cnt_o = '0;
    for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
      if (MODE) begin
        if (in_i[int'(WIDTH) - 1 - i]) cnt_o = CNT_WIDTH'(i);
      end else begin
        if (in_i[i]) cnt_o = CNT_WIDTH'(i);
      end
    end
  end

  assign empty_o = ~|in_i;

endmodule

// File: rtl/ace_ccu_snoop_fanout.sv
// Broadcasts one snoop to the cache ports selected by a domain mask, merges
// their CR responses and forwards the CD data of exactly one responder.
module ace_ccu_snoop_fanout
  import ccu_pkg::*;
#(
  parameter int unsigned NoCachePorts = 4
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  snoop_req_t                      slv_snoop_req_i,
  output snoop_resp_t                     slv_snoop_resp_o,
  input  logic        [NoCachePorts-1:0]  slv_mask_i,
  output snoop_req_t  [NoCachePorts-1:0]  mst_snoop_reqs_o,
  input  snoop_resp_t [NoCachePorts-1:0]  mst_snoop_resps_i
);

  localparam int unsigned SelWidth = (NoCachePorts > 1) ? $clog2(NoCachePorts) : 1;

  typedef logic [NoCachePorts-1:0] domain_mask_t;
  typedef logic [SelWidth-1:0]     sel_t;

  fanout_state_e state_q, state_d;
  ace_ac_t       ac_q, ac_d;
  domain_mask_t  ac_pend_q, ac_pend_d;
  domain_mask_t  cr_pend_q, cr_pend_d;
  domain_mask_t  dt_vec_q, dt_vec_d;
  domain_mask_t  drain_q, drain_d;
  ace_crresp_t   cr_acc_q, cr_acc_d;
  sel_t          sel_q, sel_d;
  logic          sel_done_q, sel_done_d;

  sel_t dt_sel;
  logic dt_empty;

  lzc #(
    .WIDTH (NoCachePorts),
    .MODE  (1'b0)
  ) i_sel_lzc (
    .in_i    (dt_vec_q),
    .cnt_o   (dt_sel),
    .empty_o (dt_empty)
  );

  // A port's CR is only taken once its AC has gone, so a cache may answer CR
  // without any CD being accepted; CD is accepted in the data phase only.
  always_comb begin
    state_d    = state_q;
    ac_d       = ac_q;
    ac_pend_d  = ac_pend_q;
    cr_pend_d  = cr_pend_q;
    dt_vec_d   = dt_vec_q;
    drain_d    = drain_q;
    cr_acc_d   = cr_acc_q;
    sel_d      = sel_q;
    sel_done_d = sel_done_q;

    slv_snoop_resp_o = '0;
    mst_snoop_reqs_o = '0;
    for (int i = 0; i < int'(NoCachePorts); i++) begin
      mst_snoop_reqs_o[i].ac = ac_q;
    end

    case (state_q)
      FanoutIdle: begin
        slv_snoop_resp_o.ac_ready = 1'b1;
        if (slv_snoop_req_i.ac_valid) begin
          ac_d      = slv_snoop_req_i.ac;
          ac_pend_d = slv_mask_i;
          cr_pend_d = slv_mask_i;
          dt_vec_d  = '0;
          cr_acc_d  = '0;
          state_d   = (slv_mask_i == '0) ? FanoutResp : FanoutBcast;
        end
      end

      FanoutBcast: begin
        for (int i = 0; i < int'(NoCachePorts); i++) begin
          mst_snoop_reqs_o[i].ac_valid = ac_pend_q[i];
          mst_snoop_reqs_o[i].cr_ready = cr_pend_q[i] & ~ac_pend_q[i];
          if (ac_pend_q[i] && mst_snoop_resps_i[i].ac_ready) begin
            ac_pend_d[i] = 1'b0;
          end
          if (cr_pend_q[i] && !ac_pend_q[i] && mst_snoop_resps_i[i].cr_valid) begin
            cr_pend_d[i] = 1'b0;
            cr_acc_d     = merge_crresp(cr_acc_d, mst_snoop_resps_i[i].cr_resp);
            dt_vec_d[i]  = mst_snoop_resps_i[i].cr_resp[CrDataTransfer];
          end
        end
        if ((ac_pend_d == '0) && (cr_pend_d == '0)) begin
          state_d = FanoutResp;
        end
      end

      FanoutResp: begin
        slv_snoop_resp_o.cr_valid = 1'b1;
        slv_snoop_resp_o.cr_resp  = cr_acc_q;
        if (slv_snoop_req_i.cr_ready) begin
          if (cr_acc_q[CrDataTransfer] && !dt_empty) begin
            state_d    = FanoutData;
            sel_d      = dt_sel;
            drain_d    = dt_vec_q & ~(domain_mask_t'(1) << dt_sel);
            sel_done_d = 1'b0;
          end else begin
            state_d = FanoutIdle;
          end
        end
      end

      FanoutData: begin
        // The selected port is a pure wire path; everyone else is drained.
        if (!sel_done_q) begin
          slv_snoop_resp_o.cd_valid         = mst_snoop_resps_i[sel_q].cd_valid;
          slv_snoop_resp_o.cd               = mst_snoop_resps_i[sel_q].cd;
          mst_snoop_reqs_o[sel_q].cd_ready  = slv_snoop_req_i.cd_ready;
          if (mst_snoop_resps_i[sel_q].cd_valid && slv_snoop_req_i.cd_ready &&
              mst_snoop_resps_i[sel_q].cd.last) begin
            sel_done_d = 1'b1;
          end
        end
        for (int i = 0; i < int'(NoCachePorts); i++) begin
          if (drain_q[i]) begin
            mst_snoop_reqs_o[i].cd_ready = 1'b1;
            if (mst_snoop_resps_i[i].cd_valid && mst_snoop_resps_i[i].cd.last) begin
              drain_d[i] = 1'b0;
            end
          end
        end
        if (sel_done_d && (drain_d == '0)) begin
          state_d = FanoutIdle;
        end
      end

      default: state_d = FanoutIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= FanoutIdle;
      ac_q       <= '0;
      ac_pend_q  <= '0;
      cr_pend_q  <= '0;
      dt_vec_q   <= '0;
      drain_q    <= '0;
      cr_acc_q   <= '0;
      sel_q      <= '0;
      sel_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ac_q       <= ac_d;
      ac_pend_q  <= ac_pend_d;
      cr_pend_q  <= cr_pend_d;
      dt_vec_q   <= dt_vec_d;
      drain_q    <= drain_d;
      cr_acc_q   <= cr_acc_d;
      sel_q      <= sel_d;
      sel_done_q <= sel_done_d;
    end
  end

endmodule
